// File: rtl/alu_req_arbiter.sv
// Round-robin front end that shares one pipelined ALU between NUM_REQ requesters.
// A tag pipe matched to the ALU latency steers each result and its normalised flags back to the issuer.
module alu_req_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 128,
  parameter int unsigned OP_W    = 4,
  parameter int unsigned SH_W    = 5,
  parameter int unsigned ALU_LAT = 2,
  parameter int unsigned NOP_OP  = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*OP_W-1:0]   req_opcode,
  input  logic [NUM_REQ*WIDTH-1:0]  req_a,
  input  logic [NUM_REQ*WIDTH-1:0]  req_b,
  input  logic [NUM_REQ*SH_W-1:0]   req_shift,
  output logic [OP_W-1:0]           alu_opcode,
  output logic [WIDTH-1:0]          alu_input1,
  output logic [WIDTH-1:0]          alu_input2,
  output logic [SH_W-1:0]           alu_shiftValue,
  input  logic [WIDTH-1:0]          alu_result,
  input  logic                      alu_carry,
  input  logic                      alu_overflow,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [WIDTH-1:0]          rsp_result,
  output logic                      rsp_carry,
  output logic                      rsp_zero,
  output logic                      rsp_overflow,
  output logic [NUM_REQ-1:0]        busy
);

  localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [OP_W-1:0] OP_ADD = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(1);

  logic [ID_W-1:0]               ptr;
  logic [NUM_REQ-1:0]            eligible;
  logic                          grant_any;
  logic [ID_W-1:0]               grant_id;
  logic [ID_W:0]                 scan_sum;
  logic                          is_addsub;

  logic [ALU_LAT-1:0]            tag_valid;
  logic [ALU_LAT-1:0][ID_W-1:0]  tag_id;
  logic [ALU_LAT-1:0]            tag_addsub;
  logic                          rsp_fire;

  // Round-robin scan starting at the pointer; requesters with an op in flight are skipped.
  always_comb begin : grant_scan
    eligible  = req_valid & ~busy;
    grant_any = 1'b0;
    grant_id  = '0;
    scan_sum  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan_sum = {1'b0, ptr} + (ID_W+1)'(k);
      if (scan_sum >= (ID_W+1)'(NUM_REQ)) begin
        scan_sum = scan_sum - (ID_W+1)'(NUM_REQ);
      end
      if (!grant_any && eligible[scan_sum[ID_W-1:0]]) begin
        grant_any = 1'b1;
        grant_id  = scan_sum[ID_W-1:0];
      end
    end
    if (rst) begin
      grant_any = 1'b0;
      grant_id  = '0;
    end
  end

  // Granted slice goes straight to the ALU; idle cycles present an undecoded opcode.
  always_comb begin : alu_drive
    req_ready      = '0;
    alu_opcode     = OP_W'(NOP_OP);
    alu_input1     = '0;
    alu_input2     = '0;
    alu_shiftValue = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_any && (grant_id == ID_W'(i))) begin
        req_ready[i]   = 1'b1;
        alu_opcode     = req_opcode[i*OP_W +: OP_W];
        alu_input1     = req_a[i*WIDTH +: WIDTH];
        alu_input2     = req_b[i*WIDTH +: WIDTH];
        alu_shiftValue = req_shift[i*SH_W +: SH_W];
      end
    end
    is_addsub = grant_any && ((alu_opcode == OP_ADD) || (alu_opcode == OP_SUB));
  end

  // Tag pipe: one stage per ALU cycle so the last stage lines up with alu_result.
  always_ff @(posedge clk) begin : tag_pipe
    if (rst) begin
      tag_valid  <= '0;
      tag_id     <= '0;
      tag_addsub <= '0;
    end else begin
      tag_valid[0]  <= grant_any;
      tag_id[0]     <= grant_id;
      tag_addsub[0] <= is_addsub;
      for (int unsigned s = 1; s < ALU_LAT; s++) begin
        tag_valid[s]  <= tag_valid[s-1];
        tag_id[s]     <= tag_id[s-1];
        tag_addsub[s] <= tag_addsub[s-1];
      end
    end
  end

  // Response: routed by the tag, flags masked to ADD/SUB, zero recomputed locally.
  always_comb begin : rsp_route
    rsp_fire     = tag_valid[ALU_LAT-1] & ~rst;
    rsp_valid    = '0;
    rsp_result   = '0;
    rsp_carry    = 1'b0;
    rsp_zero     = 1'b0;
    rsp_overflow = 1'b0;
    if (rsp_fire) begin
      rsp_valid    = NUM_REQ'(1) << tag_id[ALU_LAT-1];
      rsp_result   = alu_result;
      rsp_carry    = tag_addsub[ALU_LAT-1] & alu_carry;
      rsp_zero     = (alu_result == '0);
      rsp_overflow = tag_addsub[ALU_LAT-1] & alu_overflow;
    end
  end

  // Pointer advances past the winner; busy spans issue through the response cycle.
  always_ff @(posedge clk) begin : arb_state
    if (rst) begin
      ptr  <= '0;
      busy <= '0;
    end else begin
      if (grant_any) begin
        ptr <= (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + ID_W'(1);
      end
      busy <= (busy & ~rsp_valid) | req_ready;
    end
  end

endmodule
